// File: rtl/bcd_bin.sv
// bcd_bin: sequential packed-BCD to unsigned binary converter.
//
// Uses the reverse double-dabble algorithm. Each SHIFT cycle shifts the
// {bcd, binary} work register right by one bit, then subtracts 3 from every
// BCD nibble that reads >= 8. After BW iterations the low BW bits hold the
// binary value. A request with any nibble > 9 is rejected in one cycle with
// err=1 and bin_out=0.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   start   - conversion request, accepted only while idle
//   bcd_in  - NDIG packed BCD digits, most significant digit in the top nibble
//   busy    - high while a conversion is shifting
//   done    - one-cycle pulse: bin_out/err are valid
//   err     - last accepted request contained a nibble > 9
//   bin_out - unsigned binary result, held until the next accepted request
module bcd_bin #(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BW-1:0]     bin_out
);

    localparam int WW = 4 * NDIG + BW;
    localparam int CW = $clog2(BW + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [BW-1:0]   bin_q, bin_d;

    logic            bad_digit;
    logic [WW-1:0]   adj;

    // Invalid-digit detection on the live input (used only on the accepting edge).
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One iteration: shift right, then correct every BCD nibble that reads >= 8.
    // A nibble >= 8 after the shift means a "ten" was halved into it; subtracting
    // 3 turns 8..12 back into the correct 5..9.
    always_comb begin
        adj = work_q >> 1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (adj[BW + 4*i +: 4] >= 4'd8) begin
                adj[BW + 4*i +: 4] = adj[BW + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        err_d  = 1'b1;
                        bin_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        work_d  = {bcd_in, {BW{1'b0}}};
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = adj;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(BW - 1)) begin
                    bin_d   = adj[BW-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = bin_q;

endmodule
